// File: rtl/pc_flag_ctrl_if.sv
// Bus between the ALU/decode side and the PC/flag stage.
// The br_cnt signal exists only when PC_BRCNT_EN is defined.
interface pc_flag_ctrl_if;
  localparam int unsigned DW = 16;
  localparam int unsigned FW = 3;

  logic [DW-1:0] instr;
  logic [FW-1:0] alu_flags;
  logic [FW-1:0] flag_en;
  logic [DW-1:0] br_reg;
  logic          stall;
  logic [DW-1:0] pc;
  logic [DW-1:0] pc_plus2;
  logic [FW-1:0] flags;
  logic          taken;
  logic          halted;
`ifdef PC_BRCNT_EN
  logic [DW-1:0] br_cnt;
`endif

  modport master (
    output instr, alu_flags, flag_en, br_reg, stall,
    input  pc, pc_plus2, flags, taken, halted
`ifdef PC_BRCNT_EN
    , input br_cnt
`endif
  );

  modport slave (
    input  instr, alu_flags, flag_en, br_reg, stall,
    output pc, pc_plus2, flags, taken, halted
`ifdef PC_BRCNT_EN
    , output br_cnt
`endif
  );
endinterface

// File: rtl/pc_flag_ctrl.sv
// WISC-F23 PC / N-Z-V flag stage with a run/halt FSM and stall gating.
// Optional taken-branch counter enabled by defining PC_BRCNT_EN.
module pc_flag_ctrl (
  input  logic           clk,
  input  logic           rst,
  pc_flag_ctrl_if.slave  bus
);
  localparam int unsigned DW = 16;
  localparam int unsigned FW = 3;

  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [DW-1:0] pc_q, pc_d;
  logic [FW-1:0] flags_q, flags_d;
`ifdef PC_BRCNT_EN
  logic [DW-1:0] cnt_q, cnt_d;
`endif

  logic [3:0]    opcode;
  logic [2:0]    ccc;
  logic [8:0]    imm9;
  logic          flag_n, flag_z, flag_v;
  logic          cond_met;
  logic          is_branch;
  logic          taken_c;
  logic          upd_en;
  logic [DW-1:0] pc_plus2_c;
  logic [DW-1:0] br_off;
  logic [DW-1:0] target;

  assign opcode = bus.instr[15:12];
  assign ccc    = bus.instr[11:9];
  assign imm9   = bus.instr[8:0];
  assign flag_n = flags_q[2];
  assign flag_z = flags_q[1];
  assign flag_v = flags_q[0];

  // Branch condition on registered flags only
  always_comb begin
    cond_met = 1'b0;
    case (ccc)
      3'b000:  cond_met = !flag_z;
      3'b001:  cond_met = flag_z;
      3'b010:  cond_met = !flag_z && !flag_n;
      3'b011:  cond_met = flag_n;
      3'b100:  cond_met = flag_z || (!flag_z && !flag_n);
      3'b101:  cond_met = flag_n || flag_z;
      3'b110:  cond_met = flag_v;
      default: cond_met = 1'b1;
    endcase
  end

  assign is_branch  = (opcode == OP_B) || (opcode == OP_BR);
  assign taken_c    = is_branch && cond_met && (state_q == ST_RUN);
  assign upd_en     = (state_q == ST_RUN) && !bus.stall;
  assign pc_plus2_c = DW'(pc_q + DW'(2));
  assign br_off     = {{6{imm9[8]}}, imm9, 1'b0};
  assign target     = (opcode == OP_BR) ? bus.br_reg : DW'(pc_plus2_c + br_off);

  // Next-state: everything holds unless running and not stalled
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flags_d = flags_q;
`ifdef PC_BRCNT_EN
    cnt_d   = cnt_q;
`endif
    if (upd_en) begin
      flags_d = (flags_q & ~bus.flag_en) | (bus.alu_flags & bus.flag_en);
      if (opcode == OP_HLT) begin
        state_d = ST_HALT;
      end else begin
        pc_d = taken_c ? target : pc_plus2_c;
      end
`ifdef PC_BRCNT_EN
      if (taken_c) begin
        cnt_d = DW'(cnt_q + DW'(1));
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
      flags_q <= '0;
`ifdef PC_BRCNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flags_q <= flags_d;
`ifdef PC_BRCNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_plus2 = pc_plus2_c;
  assign bus.flags    = flags_q;
  assign bus.taken    = taken_c;
  assign bus.halted   = (state_q == ST_HALT);
`ifdef PC_BRCNT_EN
  assign bus.br_cnt   = cnt_q;
`endif
endmodule

// File: tb/tb_pc_flag_ctrl.sv
// Directed self-checking bench for pc_flag_ctrl; expected values are hand-derived.
module tb_pc_flag_ctrl;
  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  pc_flag_ctrl_if bus_if ();

  pc_flag_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, passed=%0d total=%0d", n_pass, n_total);
    $fatal(1);
  end

  task automatic drive(input logic [15:0] ins, input logic [2:0] alu,
                       input logic [2:0] fen, input logic [15:0] brr, input logic stl);
    bus_if.instr     = ins;
    bus_if.alu_flags = alu;
    bus_if.flag_en   = fen;
    bus_if.br_reg    = brr;
    bus_if.stall     = stl;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    drive(16'h0000, 3'b000, 3'b000, 16'h0000, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_total++; if (bus_if.pc !== 16'h0000) $display("FAIL reset_pc: got %h want 0000", bus_if.pc); else n_pass++;
    n_total++; if (bus_if.flags !== 3'b000) $display("FAIL reset_flags: got %b want 000", bus_if.flags); else n_pass++;
    n_total++; if (bus_if.halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", bus_if.halted); else n_pass++;
    n_total++; if (bus_if.pc_plus2 !== 16'h0002) $display("FAIL reset_pc_plus2: got %h want 0002", bus_if.pc_plus2); else n_pass++;
`ifdef PC_BRCNT_EN
    n_total++; if (bus_if.br_cnt !== 16'h0000) $display("FAIL reset_br_cnt: got %h want 0000", bus_if.br_cnt); else n_pass++;
`endif
  endtask

  task automatic test_sequential;
    logic [15:0] exp_pc [0:2];
    exp_pc[0] = 16'h0002; exp_pc[1] = 16'h0004; exp_pc[2] = 16'h0006;
    for (int i = 0; i < 3; i++) begin
      n_total++; if (bus_if.taken !== 1'b0) $display("FAIL seq_taken[%0d]: got %b want 0", i, bus_if.taken); else n_pass++;
      step();
      n_total++; if (bus_if.pc !== exp_pc[i]) $display("FAIL seq_pc[%0d]: got %h want %h", i, bus_if.pc, exp_pc[i]); else n_pass++;
    end
    // reset between edges must take effect without a clock edge
    #2 rst = 1'b1;
    #1;
    n_total++; if (bus_if.pc !== 16'h0000) $display("FAIL async_rst_pc: got %h want 0000", bus_if.pc); else n_pass++;
    #1 rst = 1'b0;
  endtask

  task automatic test_branch_b;
    // BR always to 0x000E
    drive(16'hDE00, 3'b000, 3'b000, 16'h000E, 1'b0);
    #1;
    n_total++; if (bus_if.taken !== 1'b1) $display("FAIL br_always_taken: got %b want 1", bus_if.taken); else n_pass++;
    step();
    n_total++; if (bus_if.pc !== 16'h000E) $display("FAIL br_always_pc: got %h want 000E", bus_if.pc); else n_pass++;
    // SUB producing Z=1
    drive(16'h1000, 3'b010, 3'b111, 16'h0000, 1'b0);
    step();
    n_total++; if (bus_if.pc !== 16'h0010) $display("FAIL sub_pc: got %h want 0010", bus_if.pc); else n_pass++;
    n_total++; if (bus_if.flags !== 3'b010) $display("FAIL sub_flags: got %b want 010", bus_if.flags); else n_pass++;
    // B ccc=001 imm=-2 at 0x0010: 0x0012 - 4 = 0x000E
    drive(16'hC3FE, 3'b000, 3'b000, 16'h0000, 1'b0);
    #1;
    n_total++; if (bus_if.taken !== 1'b1) $display("FAIL b_eq_taken: got %b want 1", bus_if.taken); else n_pass++;
    n_total++; if (bus_if.pc_plus2 !== 16'h0012) $display("FAIL b_eq_pc_plus2: got %h want 0012", bus_if.pc_plus2); else n_pass++;
    step();
    n_total++; if (bus_if.pc !== 16'h000E) $display("FAIL b_eq_pc: got %h want 000E", bus_if.pc); else n_pass++;
    // B ccc=000 (Z=0) with Z=1: falls through
    drive(16'hC1FE, 3'b000, 3'b000, 16'h0000, 1'b0);
    #1;
    n_total++; if (bus_if.taken !== 1'b0) $display("FAIL b_ne_taken: got %b want 0", bus_if.taken); else n_pass++;
    step();
    n_total++; if (bus_if.pc !== 16'h0010) $display("FAIL b_ne_pc: got %h want 0010", bus_if.pc); else n_pass++;
  endtask

  task automatic test_flag_mask;
    drive(16'h0000, 3'b001, 3'b111, 16'h0000, 1'b0);
    step();
    n_total++; if (bus_if.flags !== 3'b001) $display("FAIL flag_load_all: got %b want 001", bus_if.flags); else n_pass++;
    drive(16'h2000, 3'b111, 3'b010, 16'h0000, 1'b0);
    step();
    n_total++; if (bus_if.flags !== 3'b011) $display("FAIL flag_mask_z: got %b want 011", bus_if.flags); else n_pass++;
    n_total++; if (bus_if.pc !== 16'h0014) $display("FAIL flag_mask_pc: got %h want 0014", bus_if.pc); else n_pass++;
    // N=1 with ccc=011 taken, ccc=010 not
    drive(16'h0000, 3'b100, 3'b111, 16'h0000, 1'b0);
    step();
    drive(16'hC600, 3'b000, 3'b000, 16'h0000, 1'b0);
    #1;
    n_total++; if (bus_if.taken !== 1'b1) $display("FAIL b_neg_taken: got %b want 1", bus_if.taken); else n_pass++;
    drive(16'hC400, 3'b000, 3'b000, 16'h0000, 1'b0);
    #1;
    n_total++; if (bus_if.taken !== 1'b0) $display("FAIL b_gt_taken: got %b want 0", bus_if.taken); else n_pass++;
    step();
    n_total++; if (bus_if.pc !== 16'h0018) $display("FAIL b_gt_pc: got %h want 0018", bus_if.pc); else n_pass++;
  endtask

  task automatic test_br;
    drive(16'h0000, 3'b000, 3'b111, 16'h0000, 1'b0);
    step();
    n_total++; if (bus_if.flags !== 3'b000) $display("FAIL flag_clear: got %b want 000", bus_if.flags); else n_pass++;
    drive(16'hDE00, 3'b000, 3'b000, 16'hABCD, 1'b0);
    step();
    n_total++; if (bus_if.pc !== 16'hABCD) $display("FAIL br_reg_pc: got %h want ABCD", bus_if.pc); else n_pass++;
    drive(16'hDC00, 3'b000, 3'b000, 16'h1234, 1'b0);
    #1;
    n_total++; if (bus_if.taken !== 1'b0) $display("FAIL br_v_taken: got %b want 0", bus_if.taken); else n_pass++;
    step();
    n_total++; if (bus_if.pc !== 16'hABCF) $display("FAIL br_v_pc: got %h want ABCF", bus_if.pc); else n_pass++;
  endtask

  task automatic test_wrap;
    drive(16'hDE00, 3'b000, 3'b000, 16'hFFFE, 1'b0);
    step();
    drive(16'h0000, 3'b000, 3'b000, 16'h0000, 1'b0);
    #1;
    n_total++; if (bus_if.pc_plus2 !== 16'h0000) $display("FAIL wrap_pc_plus2: got %h want 0000", bus_if.pc_plus2); else n_pass++;
    step();
    n_total++; if (bus_if.pc !== 16'h0000) $display("FAIL wrap_pc: got %h want 0000", bus_if.pc); else n_pass++;
    drive(16'hDE00, 3'b000, 3'b000, 16'hFF00, 1'b0);
    step();
    // B always imm=+255 at 0xFF00: 0xFF02 + 0x01FE = 0x0100 (mod 2^16)
    drive(16'hCEFF, 3'b000, 3'b000, 16'h0000, 1'b0);
    step();
    n_total++; if (bus_if.pc !== 16'h0100) $display("FAIL b_wrap_pc: got %h want 0100", bus_if.pc); else n_pass++;
`ifdef PC_BRCNT_EN
    n_total++; if (bus_if.br_cnt !== 16'h0006) $display("FAIL br_cnt_total: got %h want 0006", bus_if.br_cnt); else n_pass++;
`endif
  endtask

  task automatic test_halt;
    drive(16'hF000, 3'b111, 3'b111, 16'h0000, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step();
      n_total++; if (bus_if.halted !== 1'b0) $display("FAIL hlt_stall_halted[%0d]: got %b want 0", i, bus_if.halted); else n_pass++;
      n_total++; if (bus_if.pc !== 16'h0100) $display("FAIL hlt_stall_pc[%0d]: got %h want 0100", i, bus_if.pc); else n_pass++;
      n_total++; if (bus_if.flags !== 3'b000) $display("FAIL hlt_stall_flags[%0d]: got %b want 000", i, bus_if.flags); else n_pass++;
    end
    drive(16'hF000, 3'b000, 3'b000, 16'h0000, 1'b0);
    step();
    n_total++; if (bus_if.halted !== 1'b1) $display("FAIL hlt_halted: got %b want 1", bus_if.halted); else n_pass++;
    n_total++; if (bus_if.pc !== 16'h0100) $display("FAIL hlt_pc: got %h want 0100", bus_if.pc); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      drive((i % 2 == 0) ? 16'hCEFF : 16'hDE00, 3'b111, 3'b111,
            16'(16'h1111 * i), (i % 3 == 2));
      #1;
      n_total++; if (bus_if.taken !== 1'b0) $display("FAIL halt_taken[%0d]: got %b want 0", i, bus_if.taken); else n_pass++;
      step();
      n_total++; if (bus_if.pc !== 16'h0100) $display("FAIL halt_pc[%0d]: got %h want 0100", i, bus_if.pc); else n_pass++;
      n_total++; if (bus_if.halted !== 1'b1) $display("FAIL halt_halted[%0d]: got %b want 1", i, bus_if.halted); else n_pass++;
      n_total++; if (bus_if.flags !== 3'b000) $display("FAIL halt_flags[%0d]: got %b want 000", i, bus_if.flags); else n_pass++;
`ifdef PC_BRCNT_EN
      n_total++; if (bus_if.br_cnt !== 16'h0006) $display("FAIL halt_br_cnt[%0d]: got %h want 0006", i, bus_if.br_cnt); else n_pass++;
`endif
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    drive(16'h0000, 3'b000, 3'b000, 16'h0000, 1'b0);
    test_reset();
    test_sequential();
    test_branch_b();
    test_flag_mask();
    test_br();
    test_wrap();
    test_halt();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
